// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types for the CPU memory subsystem.
//   arb_state_e : shared-memory arbiter FSM states
//   OWNER_I/D   : encoding of the requester that owns or last owned the port
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an instruction-fetch requester (i_*) and a
//   data requester (d_*). At most one memory transaction is outstanding; the
//   response is routed back combinationally to whichever side owns it.
//
//   Build option: define MEM_ARB_RR_EN for strict alternation on contention;
//   without it the data side always wins a tie.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   i_req_i, i_addr_i                fetch request (held until i_gnt_o)
//   i_gnt_o, i_rvalid_o, i_rdata_o   fetch accept / response
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i                data request (held until d_gnt_o)
//   d_gnt_o, d_rvalid_o, d_rdata_o   data accept / response
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o            shared memory request
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                      memory accept / response
// ----------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_req_i,
    input  logic [AW-1:0]   i_addr_i,
    output logic            i_gnt_o,
    output logic            i_rvalid_o,
    output logic [DW-1:0]   i_rdata_o,

    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_be_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       sel;
    logic       idle;

    // rst_n is folded in so mem_req_o and the grants stay low while reset is
    // held, even though the requesters may already be asserting.
    assign idle = rst_n && (state_q == IDLE);

    // Requester selection and the combinational request mux.
    always_comb begin
        sel = OWNER_I;
        if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
            sel = ~last_owner_q;
`else
            sel = OWNER_D;
`endif
        end else if (d_req_i) begin
            sel = OWNER_D;
        end

        mem_req_o = idle && (i_req_i || d_req_i);

        if (sel == OWNER_D) begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_addr_o  = i_addr_i;
            mem_wdata_o = '0;
            mem_be_o    = '1;
        end

        i_gnt_o = mem_req_o && mem_gnt_i && (sel == OWNER_I);
        d_gnt_o = mem_req_o && mem_gnt_i && (sel == OWNER_D);
    end

    // Next state and response routing. A response arriving while IDLE (e.g.
    // one orphaned by reset) falls through to the defaults and is dropped.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        i_rvalid_o   = 1'b0;
        d_rvalid_o   = 1'b0;
        i_rdata_o    = '0;
        d_rdata_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (mem_req_o && mem_gnt_i) begin
                    state_d      = (sel == OWNER_D) ? BUSY_D : BUSY_I;
                    last_owner_d = sel;
                end
            end
            BUSY_I: begin
                if (mem_rvalid_i) begin
                    state_d    = IDLE;
                    i_rvalid_o = 1'b1;
                    i_rdata_o  = mem_rdata_i;
                end
            end
            BUSY_D: begin
                if (mem_rvalid_i) begin
                    state_d    = IDLE;
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_D;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of all ports.
REQ-002 Parameter DW, default 32: data width of all ports; byte-enable width is DW/8.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_i  input  1  instruction-fetch request; held with i_addr_i until i_gnt_o.
REQ-006 i_addr_i  input  AW  fetch address.
REQ-007 i_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid_o, i_rdata_o  output  1, DW  fetch response strobe and data.
REQ-009 d_req_i, d_we_i  input  1, 1  data request and write flag; held with all d_* fields until d_gnt_o.
REQ-010 d_addr_i, d_wdata_i, d_be_i  input  AW, DW, DW/8  data address, write data, byte enables.
REQ-011 d_gnt_o, d_rvalid_o, d_rdata_o  output  1, 1, DW  data accept, response strobe (reads and writes), read data.
REQ-012 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  output  1, 1, AW, DW, DW/8  single shared memory port request.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_rdata_i  input  1, 1, DW  memory accept, response strobe (one per accepted request), response data.

Function
REQ-014 FSM states IDLE, BUSY_I, BUSY_D; at most one outstanding memory transaction.
REQ-015 IDLE: mem_req_o = i_req_i | d_req_i; mem_* fields driven combinationally from the selected requester.
REQ-016 Selection when only one requester is active: that requester.
REQ-017 Selection when both are active: per REQ-029/REQ-030.
REQ-018 Fetch selected: mem_we_o = 0 and mem_be_o = all ones.
REQ-019 Grant pass-through: i_gnt_o/d_gnt_o = mem_gnt_i & (IDLE) & selected; never both high in one cycle.
REQ-020 Transitions: IDLE -> BUSY_I or BUSY_D on mem_gnt_i, per owner; BUSY_x -> IDLE on mem_rvalid_i.
REQ-021 BUSY_x: mem_req_o = 0; i_gnt_o = d_gnt_o = 0.
REQ-022 Response routing: on mem_rvalid_i, owner's rvalid = 1 for exactly that cycle, owner's rdata = mem_rdata_i; non-owner rdata = 0.
REQ-023 Response path adds zero latency (combinational).
REQ-024 Back-to-back: a new grant is possible the cycle after rvalid; minimum 2 cycles per transaction.
REQ-025 mem_rvalid_i in IDLE is ignored: no rvalid output and no state change.
REQ-026 Registered last_owner (0 = I, 1 = D) updates on every grant.

Reset
REQ-027 Async assert, any state -> IDLE, last_owner = 1 (D); an in-flight response is dropped, and a later mem_rvalid_i is ignored per REQ-025.
REQ-028 During reset, all outputs are 0 except combinational mem_* mux values, which are don't-care while mem_req_o = 0.

Configuration
REQ-029 Macro MEM_ARB_RR_EN defined: on contention, grant the requester that is not last_owner (strict alternation).
REQ-030 Macro MEM_ARB_RR_EN undefined: on contention, D always wins (fixed priority); last_owner is still maintained but does not affect selection.

Structure
REQ-031 Shared package cpu_pkg: arb_state_e enum (IDLE, BUSY_I, BUSY_D) and owner constants OWNER_I = 1'b0, OWNER_D = 1'b1.
REQ-032 Single flat module with no sub-modules; the selection logic is one always_comb block.

Verification
REQ-033 Fetch alone: i_req_i = 1, i_addr_i = 0x100, mem_gnt_i = 1 -> mem_addr_o = 0x100, mem_we_o = 0, i_gnt_o = 1; mem_rvalid_i with 0xDEADBEEF two cycles later -> i_rvalid_o = 1, i_rdata_o = 0xDEADBEEF, d_rvalid_o = 0.
REQ-034 Contention, MEM_ARB_RR_EN undefined: both requesting every cycle, memory always granting, rvalid 1 cycle after grant -> grant order D, D, D, and i_gnt_o never asserts.
REQ-035 Contention, MEM_ARB_RR_EN defined, same stimulus -> grant order I, D, I, D, with first grant I since last_owner resets to D.
REQ-036 Store: d_we_i = 1, d_addr_i = 0x2004, d_wdata_i = 0x000000AB, d_be_i = 4'b0001 -> mem outputs match; d_rvalid_o pulses once on mem_rvalid_i.
REQ-037 Reset mid-transaction: rst_n low in BUSY_D, then high; stray mem_rvalid_i -> no rvalid output, state IDLE, next i_req_i granted normally.
REQ-038 Memory stall: mem_gnt_i = 0 for 5 cycles with i_req_i held -> mem_req_o stays 1, i_gnt_o stays 0, state stays IDLE; grant on cycle 6.
